// File: rtl/pipemem_stage.sv
// pipemem_stage: EXE/MEM boundary register with a req/ack data-memory access controller
//   clk, clrn                      clock (rising edge), asynchronous active-low reset
//   ealu, eb, ern                  EXE result/address, store data, destination register
//   ewreg, em2reg, ewmem           EXE control: register write, load, store
//   mstall                         freeze upstream pipeline while an access is outstanding
//   d_req, d_we, d_addr, d_wdata   data-memory request port
//   d_rdata, d_ack                 data-memory response
//   malu, mmo, mrn, mwreg, mm2reg  MEM results towards MEM/WB
//   mexc                           one-cycle exception pulse (misaligned access or timeout)
module pipemem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    output logic        mstall,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata,
    input  logic        d_ack,
    output logic [31:0] malu,
    output logic [31:0] mmo,
    output logic [4:0]  mrn,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mexc
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q, state_d;
    logic [31:0] malu_q, malu_d, eb_q, eb_d;
    logic [4:0]  mrn_q, mrn_d;
    logic        mwreg_q, mwreg_d, mm2reg_q, mm2reg_d, mwmem_q, mwmem_d;
    logic        mis_q, mis_d, mexc_q, mexc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy, abort, capture, mem_op, misal;
    always_comb begin
        busy     = state_q == BUSY;
        abort    = busy & ~d_ack & (cnt_q == 16'(TIMEOUT - 1));
        mstall   = busy & ~d_ack & ~abort;
        capture  = ~mstall;
        mem_op   = em2reg | ewmem;
        misal    = mem_op & (ealu[1:0] != 2'b00);
        malu_d   = capture ? ealu   : malu_q;
        eb_d     = capture ? eb     : eb_q;
        mrn_d    = capture ? ern    : mrn_q;
        mwreg_d  = capture ? ewreg  : mwreg_q;
        mm2reg_d = capture ? em2reg : mm2reg_q;
        mwmem_d  = capture ? ewmem  : mwmem_q;
        mis_d    = capture ? misal  : mis_q;
        // a retiring access hands over directly to the next captured memory op
        state_d  = capture ? ((mem_op & ~misal) ? BUSY : IDLE) : state_q;
        // any non-capture cycle is a BUSY cycle without ack
        cnt_d    = capture ? 16'd0 : cnt_q + 16'd1;
        mexc_d   = (capture & misal) | abort;
        d_req    = busy;
        d_we     = busy & mwmem_q;
        d_addr   = busy ? malu_q : 32'd0;
        d_wdata  = busy ? eb_q : 32'd0;
        malu     = malu_q;
        mrn      = mrn_q;
        mm2reg   = mm2reg_q;
        mexc     = mexc_q;
        mwreg    = mwreg_q & ~mstall & ~mis_q & ~abort;
        // load+store together behaves as a store, so no read data is returned
        mmo      = (busy & d_ack & mm2reg_q & ~mwmem_q) ? d_rdata : 32'd0;
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            malu_q   <= '0;
            eb_q     <= '0;
            mrn_q    <= '0;
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            mis_q    <= 1'b0;
            mexc_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            malu_q   <= malu_d;
            eb_q     <= eb_d;
            mrn_q    <= mrn_d;
            mwreg_q  <= mwreg_d;
            mm2reg_q <= mm2reg_d;
            mwmem_q  <= mwmem_d;
            mis_q    <= mis_d;
            mexc_q   <= mexc_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: doc/pipemem_stage.md
Name: pipemem_stage

Overview:
- EXE/MEM boundary register plus data-memory access controller for the 5-stage MIPS32 pipeline.
- Captures the EXE stage results (ALU result, store data, destination register and control bits) and runs loads and stores over a req/ack data-memory port.
- Drives a freeze signal upstream while an access is outstanding, and presents MEM results to the MEM/WB register.

Parameters:
TIMEOUT, 255, max BUSY cycles without d_ack before the access is aborted (range 2..65535)

Ports:
clk  in  1  pipeline clock, rising edge
clrn  in  1  asynchronous active-low reset
ealu  in  32  EXE result (address for loads/stores)
eb  in  32  store data
ern  in  5  destination register
ewreg  in  1  register write enable
em2reg  in  1  load (writeback selects memory data)
ewmem  in  1  store
mstall  out  1  freeze PC/IF/ID/EXE registers this cycle
d_req  out  1  memory request
d_we  out  1  1 = write, 0 = read
d_addr  out  32  word address
d_wdata  out  32  write data
d_rdata  in  32  read data, valid when d_ack=1
d_ack  in  1  access complete this cycle
malu  out  32  registered ALU result
mmo  out  32  memory read data to MEM/WB
mrn  out  5  registered destination register
mwreg  out  1  gated write enable to MEM/WB
mm2reg  out  1  registered load flag
mexc  out  1  one-cycle exception pulse (misaligned or timeout)

Behaviour:
- Reset (clrn=0, async): state IDLE, all internal registers 0, wait counter 0. All outputs 0 immediately, including d_req.
- Capture register (malu, eb_q, mrn, mwreg_q, mm2reg, mwmem_q):
  - Loads from E inputs on every rising edge where mstall=0.
  - Holds while mstall=1.
- States:
  - IDLE: no access pending.
  - BUSY: access outstanding.
- IDLE transitions, on a capture edge:
  - em2reg|ewmem=1 and ealu[1:0]=00 -> BUSY, counter cleared.
  - em2reg|ewmem=1 and ealu[1:0]!=00 -> stay IDLE, set mis flag.
  - Otherwise stay IDLE, mis flag cleared.
  - If both em2reg and ewmem are set, treat as a store (d_we=1).
- Request outputs in BUSY:
  - d_req=1, d_we=mwmem_q, d_addr=malu, d_wdata=eb_q.
  - All held stable until acknowledged or aborted.
- Request outputs in IDLE:
  - d_req=0; d_we, d_addr and d_wdata driven 0.
- mstall = (state==BUSY) & ~d_ack & ~abort, combinational.
  - Zero-wait memory (d_ack in the first BUSY cycle) produces no stall.
- d_ack in BUSY:
  - The access retires this cycle.
  - mmo = d_rdata for loads; mmo=0 for stores.
  - Next edge: state IDLE, or directly BUSY again if the newly captured instruction is an aligned memory op.
- d_ack in IDLE: ignored.
- Timeout:
  - Counter increments on each BUSY cycle with d_ack=0.
  - abort = BUSY & ~d_ack & (counter==TIMEOUT-1).
  - On abort: the instruction retires with mwreg forced 0, state goes to IDLE, and mexc=1 on the following cycle.
  - d_ack and abort in the same cycle: ack wins, no exception.
- mwreg output = mwreg_q & ~mstall & ~mis & ~abort.
  - MEM/WB therefore sees a bubble during stall cycles and exactly one write per instruction.
- mexc:
  - Registered; 1 for exactly one cycle.
  - Asserted during the cycle a misaligned op is held in the register (mis=1), or the cycle after an abort.
  - Misaligned ops issue no d_req.
- Outputs outside a retiring load:
  - mmo=0 whenever not in a retiring-load cycle.
  - malu, mrn and mm2reg always reflect the captured instruction.
- Reset mid-access: d_req drops asynchronously. A late d_ack after reset is ignored.

Test Plan:
- ALU op: ealu=0x00000010, ern=5, ewreg=1, no mem -> next cycle malu=0x10, mrn=5, mwreg=1, d_req=0, mstall=0.
- Zero-wait load: em2reg=1, ealu=0x100, d_ack=1 in the first BUSY cycle with d_rdata=0xDEADBEEF -> d_req=1, d_we=0, d_addr=0x100, mmo=0xDEADBEEF, mwreg=1, mstall never 1.
- 3-wait store: ewmem=1, ealu=0x200, eb=0x12345678, d_ack on the 4th BUSY cycle -> mstall=1 for 3 cycles, d_addr and d_wdata stable throughout, mwreg=0, then the next instruction is captured.
- Misaligned load: em2reg=1, ealu=0x102 -> no d_req, mwreg=0, mexc=1 for one cycle.
- Timeout with TIMEOUT=4: load with d_ack held 0 -> mstall=1 for 3 cycles, state IDLE after cycle 4, mexc=1 the next cycle, mwreg=0.
- Reset during BUSY: assert clrn=0 mid-wait -> d_req, mstall and all outputs go 0 immediately. After release: IDLE, and a stray d_ack is ignored.
